// File: rtl/lru_pkg.sv
// Shared definitions for the button conditioner and the 4-entry LRU tracker.
//   NUM_BTNS    : number of push buttons / LRU entries
//   btn_state_t : per-button debounce state
//   btn_vec_t   : one bit per button, bit0 = button1
//   lowest_set  : isolates the lowest-index set bit (button1 wins)
package lru_pkg;

    localparam int unsigned NUM_BTNS = 4;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic btn_vec_t lowest_set(input btn_vec_t v);
        btn_vec_t neg;
        neg = ~v + btn_vec_t'(1);
        return v & neg;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Signal bundle between the button conditioner and its user.
//   tick        : one-cycle LRU sampling strobe, consumes the pending request
//   raw_btn     : raw, asynchronous button levels, bit0 = button1
//   b1..b4      : registered one-hot request
//   dropped     : pulse when an accepted press is discarded
//   press_count : presses loaded into pending (only with BTN_PRESS_COUNT_EN)
//   drop_count  : cycles with dropped=1, saturating (only with BTN_PRESS_COUNT_EN)
// master = driver of tick/raw_btn, slave = the conditioner.
interface btn_conditioner_if;
    import lru_pkg::*;

    logic     tick;
    btn_vec_t raw_btn;
    logic     b1;
    logic     b2;
    logic     b3;
    logic     b4;
    logic     dropped;
`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] press_count;
    logic [7:0] drop_count;
`endif

    modport master (
        output tick, raw_btn,
`ifdef BTN_PRESS_COUNT_EN
        input  press_count, drop_count,
`endif
        input  b1, b2, b3, b4, dropped
    );

    modport slave (
        input  tick, raw_btn,
`ifdef BTN_PRESS_COUNT_EN
        output press_count, drop_count,
`endif
        output b1, b2, b3, b4, dropped
    );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, debounce FSM and stability counter.
//   clk   : system clock
//   rst   : asynchronous, active-low reset
//   raw   : raw button level, asynchronous to clk
//   press : one-cycle pulse when a press has been stable for DEBOUNCE_CYCLES
module btn_debounce
    import lru_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync    = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Button input stage for the LRU tracker: debounces four raw buttons, picks one
// press per cycle (button1 highest priority) and holds it as a one-hot request
// until the LRU's tick consumes it.
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : btn_conditioner_if.slave (tick, raw_btn in; b1..b4, dropped out)
// Optional macro BTN_PRESS_COUNT_EN adds press_count (wrapping) and
// drop_count (saturating) on the interface.
module btn_conditioner
    import lru_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input logic               clk,
    input logic               rst,
    btn_conditioner_if.slave  bus
);

    btn_vec_t press;
    btn_vec_t cand;
    btn_vec_t discard;
    btn_vec_t pending_q, pending_d;
    logic     accept;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.raw_btn[i]),
            .press (press[i])
        );
    end

    // A tick frees the slot in the same cycle, so a coinciding press is kept.
    // A tick with no press simply loads zero, clearing the request.
    always_comb begin
        cand      = lowest_set(press);
        accept    = bus.tick || (pending_q == '0);
        pending_d = pending_q;
        discard   = press;
        if (accept) begin
            pending_d = cand;
            discard   = press & ~cand;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // dropped is combinational from registered debounce state, so it shows in
    // the cycle the press is discarded, one edge ahead of the winner's b*.
    assign bus.dropped = |discard;
    assign bus.b1      = pending_q[0];
    assign bus.b2      = pending_q[1];
    assign bus.b3      = pending_q[2];
    assign bus.b4      = pending_q[3];

`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] press_count_q;
    logic [7:0] drop_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (accept && (press != '0)) begin
                press_count_q <= press_count_q + 8'd1;
            end
            if (bus.dropped && (drop_count_q != 8'hff)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign bus.press_count = press_count_q;
    assign bus.drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// The driver updates a run-length reference model per clock edge and queues
// the expected outputs tagged with the edge they belong to; a monitor on the
// falling edge pops and compares them.
module tb_btn_conditioner;
    import lru_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SYNC = 2;

    typedef struct {
        int unsigned edge_no;
        logic        drop;
        logic [3:0]  b;
        logic [7:0]  pc;
        logic [7:0]  dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    exp_t        exp_q[$];
    exp_t        mon_tmp;

    // Reference model state: accepted level and length of the current run of
    // opposite samples per button; pending request as a button index.
    logic [3:0]  m_lvl;
    int          m_run[4];
    logic [3:0]  m_hist[$];
    int          m_pend;
    int          m_pc;
    int          m_dc;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    function automatic void model_reset();
        m_lvl = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(4'b0);
        m_pend = -1;
        m_pc   = 0;
        m_dc   = 0;
    endfunction

    function automatic void push_exp(input int unsigned e, input logic d);
        exp_t x;
        x.edge_no = e;
        x.drop    = d;
        x.b       = (m_pend < 0) ? 4'b0 : 4'(1 << m_pend);
        x.pc      = 8'(m_pc);
        x.dc      = 8'(m_dc);
        exp_q.push_back(x);
    endfunction

    // Advance the model across the upcoming edge using the inputs just driven.
    function automatic void model_edge();
        logic [3:0] s;
        logic [3:0] pr;
        int         cand;
        int         ndisc;
        bit         accept;
        if (!rst) begin
            model_reset();
            push_exp(cyc + 1, 1'b0);
            return;
        end
        s = m_hist.pop_front();
        m_hist.push_back(bus.raw_btn);
        pr = '0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    pr[i]    = s[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        cand = -1;
        for (int i = 0; i < 4; i++) if (pr[i] && cand < 0) cand = i;
        accept = bus.tick || (m_pend < 0);
        ndisc  = 0;
        for (int i = 0; i < 4; i++) if (pr[i] && !(accept && i == cand)) ndisc++;
        if (accept) begin
            m_pend = cand;
            if (cand >= 0) m_pc = (m_pc + 1) % 256;
        end
        if (ndisc > 0 && m_dc < 255) m_dc++;
        push_exp(cyc + 1, ndisc > 0);
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
            mon_tmp = exp_q.pop_front();
            check("missed_edge", 8'(mon_tmp.edge_no), 8'(cyc));
        end
        if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
            check("b4..b1", {4'b0, bus.b4, bus.b3, bus.b2, bus.b1}, {4'b0, exp_q[0].b});
`ifdef BTN_PRESS_COUNT_EN
            check("press_count", bus.press_count, exp_q[0].pc);
            check("drop_count", bus.drop_count, exp_q[0].dc);
`endif
            mon_tmp = exp_q.pop_front();
        end
        if (exp_q.size() > 0 && exp_q[0].edge_no == cyc + 1) begin
            check("dropped", {7'b0, bus.dropped}, {7'b0, exp_q[0].drop});
        end
    end

    task automatic step(input logic [3:0] r, input logic t, input logic rs);
        @(posedge clk);
        #1;
        rst         = rs;
        bus.raw_btn = r;
        bus.tick    = t;
        model_edge();
    endtask

    task automatic hold(input logic [3:0] r, input int n, input int tick_at);
        for (int j = 0; j < n; j++) step(r, j == tick_at, 1'b1);
    endtask

    // Assert reset between edges; the request must vanish at once.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        push_exp(cyc, 1'b0);
        push_exp(cyc + 1, 1'b0);
        #1;
        check("b_in_reset", {4'b0, bus.b4, bus.b3, bus.b2, bus.b1}, 8'h00);
    endtask

    initial begin
        logic [3:0] rr;
        int         dur[4];
        bus.raw_btn = '0;
        bus.tick    = 1'b0;
        model_reset();
        for (int j = 0; j < 3; j++) step(4'b0, 1'b0, 1'b0);

        // Clean press of button1, consumed by a tick, then released.
        hold(4'b0001, 14, 10);
        hold(4'b0000, 10, -1);

        // Bouncing button2, then stable.
        for (int k = 0; k < 2; k++) begin
            hold(4'b0010, 2, -1);
            hold(4'b0000, 2, -1);
        end
        hold(4'b0010, 12, 10);
        hold(4'b0000, 10, -1);

        // Buttons 2 and 4 together: button2 wins, button4 dropped.
        hold(4'b1010, 10, 8);
        hold(4'b0000, 10, -1);

        // b3 pending, button1 dropped; then button1 press coinciding with tick.
        hold(4'b0100, 10, -1);
        hold(4'b0101, 10, -1);
        hold(4'b0100, 8, -1);
        hold(4'b0101, 10, 6);
        hold(4'b0000, 10, 2);

        // Reset with b4 pending and button4 still held.
        hold(4'b1000, 10, -1);
        mid_reset();
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        hold(4'b1000, 12, -1);
        hold(4'b0000, 10, 3);

        // Many accepted presses (press_count wraps).
        for (int k = 0; k < 300; k++) begin
            hold(4'b0001, 7, 6);
            hold(4'b0000, 7, -1);
        end

        // Many drops while button1 stays pending (drop_count saturates).
        hold(4'b0001, 10, 6);
        for (int k = 0; k < 260; k++) begin
            hold(4'b0011, 7, -1);
            hold(4'b0001, 7, -1);
        end
        hold(4'b0000, 10, 2);

        // Random bouncy buttons and random ticks.
        rr = '0;
        for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 12);
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (dur[i] == 0) begin
                    rr[i]  = ~rr[i];
                    dur[i] = $urandom_range(1, 12);
                end
                dur[i]--;
            end
            step(rr, $urandom_range(0, 7) == 0, 1'b1);
        end
        hold(4'b0000, 12, -1);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the 4-entry LRU tracker.
- Takes raw, bouncy push-button levels and synchronises each one, then debounces it and edge-detects it.
- Arbitrates simultaneous presses and holds exactly one one-hot request (b1..b4) until the LRU's slow-clock strobe consumes it.
- Guarantees one clean, single-button request per physical press; none is lost to the slow sampling clock.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required to accept a press or a release; legal range >= 2.
- SYNC_STAGES, 2: synchroniser flop depth per button; legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  single-clk-cycle strobe marking the LRU sampling edge; a tick consumes the pending request
- raw_btn  input  4  raw button levels, bit0=button1 .. bit3=button4; asynchronous to clk
- b1, b2, b3, b4  output  1 each  registered request to the LRU; at most one high
- dropped  output  1  one-cycle pulse when an accepted press is discarded

Behaviour:
- Reset (rst=0, async): all synchroniser flops 0, all debounce FSMs RELEASED, counters 0, pending=0, b1..b4=0, dropped=0.
- Synchroniser: per bit, SYNC_STAGES flops; sync[i] is the last stage.
- Debounce FSM per button: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: sync=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT: sync=0 -> RELEASED, cnt=0. cnt==DEBOUNCE_CYCLES -> PRESSED, assert press[i] for exactly that one cycle. Otherwise cnt++.
  - PRESSED: sync=0 -> RELEASE_WAIT, cnt=1. No further press while held.
  - RELEASE_WAIT: sync=1 -> PRESSED, cnt=0. cnt==DEBOUNCE_CYCLES -> RELEASED. Otherwise cnt++.
  - Counter saturates at DEBOUNCE_CYCLES; no wrap.
- Latency: raw held high from clk edge 0 gives press[i] at edge SYNC_STAGES+DEBOUNCE_CYCLES and b* high at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Arbitration and pending register (4-bit one-hot, drives b1..b4 directly):
  - Candidate = lowest-index asserted press bit; button1 has highest priority.
  - pending=0, no tick: candidate loads pending. Other simultaneous press bits are discarded; dropped=1.
  - pending!=0, no tick: any press is discarded; dropped=1; pending unchanged.
  - tick=1: pending cleared. A press in the same cycle loads pending (new value replaces old). No dropped for that candidate.
  - tick with pending=0 and no press: no effect.
- dropped is a single pulse per cycle regardless of how many presses are discarded.
- Reset mid-operation: all state lost immediately; pending request is not delivered.
- A button held through reset release is treated as a new press and is re-debounced from RELEASED.
- Outputs are registered; no combinational path from raw_btn or tick to b1..b4.

Optional Feature:
- Macro BTN_PRESS_COUNT_EN.
- Defined:
  - Adds output press_count [7:0]: count of presses loaded into pending.
  - Increments by 1 on each load, wraps 255->0, resets to 0.
  - Adds output drop_count [7:0]: count of cycles with dropped=1.
  - Saturates at 255, resets to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Shared package lru_pkg:
  - NUM_BTNS=4.
  - typedef enum logic [1:0] btn_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - typedef logic [NUM_BTNS-1:0] btn_vec_t.
- The LRU block imports the same package for its button vector.
- Sub-module btn_debounce: one channel, holding the synchroniser, FSM and counter, with output press. Instantiated NUM_BTNS times via generate.
- Arbitration, pending and optional counters live in the top.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset then raw_btn=4'b0001 held high from edge 0 -> b1=1 at edge 7, holds; tick at edge 10 -> b1=0 at edge 11; button still held, no second request.
- raw_btn bit1 toggles 1,0,1,0 every 2 cycles, then stays high -> no request during bounce; b2=1 exactly 7 edges after the final rising transition.
- raw_btn=4'b1010 rising in the same cycle -> b2=1 only at edge 7, dropped=1 at edge 6 (button4 discarded).
- b3 pending, button1 press completes without tick -> dropped=1, b3 stays; repeat with the press coinciding with tick -> b1=1 next cycle, b3=0, dropped=0.
- b4 pending and button4 still held, rst=0 mid-cycle -> b4=0 immediately; after rst=1 -> b4=1 again 7 edges later.
- BTN_PRESS_COUNT_EN defined: 300 accepted presses -> press_count=44; 260 drops -> drop_count=255.
